// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite channel types and the bus interface shared by the requesters and the downstream slave.
package axi_lite_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;
endpackage

interface axi_lite_if;
    axi_lite_pkg::addr_t awaddr;
    logic                awvalid;
    logic                awready;
    axi_lite_pkg::data_t wdata;
    axi_lite_pkg::strb_t wstrb;
    logic                wvalid;
    logic                wready;
    axi_lite_pkg::resp_t bresp;
    logic                bvalid;
    logic                bready;
    axi_lite_pkg::addr_t araddr;
    logic                arvalid;
    logic                arready;
    axi_lite_pkg::data_t rdata;
    axi_lite_pkg::resp_t rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-requester AXI4-Lite arbiter: independent read and write FSMs, each holding one grant
// for a whole transaction, selectable round-robin or fixed (m0-first) priority.
module axi_lite_arbiter_2to1
    import axi_lite_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic          aclk,
    input  logic          areset_n,
    axi_lite_if.slave     m0,
    axi_lite_if.slave     m1,
    axi_lite_if.master    s
);

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ADDR = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_XFER = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    // Grant value 0 selects m0, 1 selects m1; last is the previous grantee on that path.
    function automatic logic pick_grant(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return RR_EN ? ~last : 1'b0;
        end else if (req1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    logic [1:0] rd_state_r, rd_state_s;
    logic       rd_gnt_r, rd_last_r, rd_pick_s;
    logic [1:0] wr_state_r, wr_state_s;
    logic       wr_gnt_r, wr_last_r, wr_pick_s;
    logic       aw_done_r, w_done_r;
    logic       aw_fwd_s, w_fwd_s, aw_hs_s, w_hs_s, g_bready_s;

    assign rd_pick_s = pick_grant(m0.arvalid, m1.arvalid, rd_last_r);
    assign wr_pick_s = pick_grant(m0.awvalid, m1.awvalid, wr_last_r);

    // Read path next-state logic.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (m0.arvalid || m1.arvalid) rd_state_s = RD_ADDR;
                else                          rd_state_s = RD_IDLE;
            end
            RD_ADDR: begin
                if (s.arready) rd_state_s = RD_DATA;
                else           rd_state_s = RD_ADDR;
            end
            RD_DATA: begin
                if (s.rvalid && s.rready) rd_state_s = RD_IDLE;
                else                      rd_state_s = RD_DATA;
            end
            default: rd_state_s = RD_IDLE;
        endcase
    end

    // Read path state, grant and last-grant registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_state_r <= RD_IDLE;
            rd_gnt_r   <= 1'b0;
            rd_last_r  <= 1'b1;
        end else begin
            rd_state_r <= rd_state_s;
            if (rd_state_r == RD_IDLE && rd_state_s == RD_ADDR) begin
                rd_gnt_r  <= rd_pick_s;
                rd_last_r <= rd_pick_s;
            end
        end
    end

    // Read path grant mux; everything not owned by the grantee stays at zero.
    always_comb begin
        s.arvalid  = 1'b0;
        s.araddr   = 32'h0000_0000;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        m0.rdata   = 32'h0000_0000;
        m1.rdata   = 32'h0000_0000;
        m0.rresp   = 2'b00;
        m1.rresp   = 2'b00;
        case (rd_state_r)
            RD_ADDR: begin
                s.arvalid = 1'b1;
                s.araddr  = rd_gnt_r ? m1.araddr : m0.araddr;
                if (rd_gnt_r) m1.arready = s.arready;
                else          m0.arready = s.arready;
            end
            RD_DATA: begin
                s.rready = rd_gnt_r ? m1.rready : m0.rready;
                if (rd_gnt_r) begin
                    m1.rvalid = s.rvalid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                end else begin
                    m0.rvalid = s.rvalid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                end
            end
            default: begin
            end
        endcase
    end

    // Write path handshake qualifiers and next-state logic.
    always_comb begin
        aw_fwd_s   = (wr_state_r == WR_XFER) && (wr_gnt_r ? m1.awvalid : m0.awvalid) && !aw_done_r;
        w_fwd_s    = (wr_state_r == WR_XFER) && (wr_gnt_r ? m1.wvalid : m0.wvalid) && !w_done_r;
        aw_hs_s    = aw_fwd_s && s.awready;
        w_hs_s     = w_fwd_s && s.wready;
        g_bready_s = (wr_state_r == WR_RESP) && (wr_gnt_r ? m1.bready : m0.bready);
        wr_state_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (m0.awvalid || m1.awvalid) wr_state_s = WR_XFER;
                else                          wr_state_s = WR_IDLE;
            end
            WR_XFER: begin
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) wr_state_s = WR_RESP;
                else                                                wr_state_s = WR_XFER;
            end
            WR_RESP: begin
                if (s.bvalid && g_bready_s) wr_state_s = WR_IDLE;
                else                        wr_state_s = WR_RESP;
            end
            default: wr_state_s = WR_IDLE;
        endcase
    end

    // Write path state, grant, last-grant and per-channel done flags.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_state_r <= WR_IDLE;
            wr_gnt_r   <= 1'b0;
            wr_last_r  <= 1'b1;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            if (wr_state_r == WR_IDLE && wr_state_s == WR_XFER) begin
                wr_gnt_r  <= wr_pick_s;
                wr_last_r <= wr_pick_s;
            end
            if (wr_state_s == WR_IDLE) begin
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end else begin
                if (aw_hs_s) aw_done_r <= 1'b1;
                if (w_hs_s)  w_done_r  <= 1'b1;
            end
        end
    end

    // Write path grant mux; AW and W advance independently while in transfer.
    always_comb begin
        s.awvalid  = aw_fwd_s;
        s.wvalid   = w_fwd_s;
        s.bready   = g_bready_s;
        s.awaddr   = 32'h0000_0000;
        s.wdata    = 32'h0000_0000;
        s.wstrb    = 4'h0;
        m0.awready = 1'b0;
        m1.awready = 1'b0;
        m0.wready  = 1'b0;
        m1.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m1.bvalid  = 1'b0;
        m0.bresp   = 2'b00;
        m1.bresp   = 2'b00;
        case (wr_state_r)
            WR_XFER: begin
                s.awaddr = wr_gnt_r ? m1.awaddr : m0.awaddr;
                s.wdata  = wr_gnt_r ? m1.wdata  : m0.wdata;
                s.wstrb  = wr_gnt_r ? m1.wstrb  : m0.wstrb;
                if (wr_gnt_r) begin
                    m1.awready = !aw_done_r && s.awready;
                    m1.wready  = !w_done_r && s.wready;
                end else begin
                    m0.awready = !aw_done_r && s.awready;
                    m0.wready  = !w_done_r && s.wready;
                end
            end
            WR_RESP: begin
                if (wr_gnt_r) begin
                    m1.bvalid = s.bvalid;
                    m1.bresp  = s.bresp;
                end else begin
                    m0.bvalid = s.bvalid;
                    m0.bresp  = s.bresp;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: a round-robin instance and a fixed-priority instance
// driven side by side, with hand-computed expectations checked on the falling clock edge.
module tb_axi_lite_arbiter_2to1;

    logic aclk;
    logic areset_n;
    int   total;
    int   bad;

    axi_lite_if m0();
    axi_lite_if m1();
    axi_lite_if sl();
    axi_lite_if f0();
    axi_lite_if f1();
    axi_lite_if fs();

    axi_lite_arbiter_2to1 #(.RR_EN(1'b1)) dut_rr (.aclk(aclk), .areset_n(areset_n), .m0(m0), .m1(m1), .s(sl));
    axi_lite_arbiter_2to1 #(.RR_EN(1'b0)) dut_fp (.aclk(aclk), .areset_n(areset_n), .m0(f0), .m1(f1), .s(fs));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        m0.awaddr = 32'h0; m0.awvalid = 1'b0; m0.wdata = 32'h0; m0.wstrb = 4'h0; m0.wvalid = 1'b0;
        m0.bready = 1'b0; m0.araddr = 32'h0; m0.arvalid = 1'b0; m0.rready = 1'b0;
        m1.awaddr = 32'h0; m1.awvalid = 1'b0; m1.wdata = 32'h0; m1.wstrb = 4'h0; m1.wvalid = 1'b0;
        m1.bready = 1'b0; m1.araddr = 32'h0; m1.arvalid = 1'b0; m1.rready = 1'b0;
        f0.awaddr = 32'h0; f0.awvalid = 1'b0; f0.wdata = 32'h0; f0.wstrb = 4'h0; f0.wvalid = 1'b0;
        f0.bready = 1'b0; f0.araddr = 32'h0; f0.arvalid = 1'b0; f0.rready = 1'b0;
        f1.awaddr = 32'h0; f1.awvalid = 1'b0; f1.wdata = 32'h0; f1.wstrb = 4'h0; f1.wvalid = 1'b0;
        f1.bready = 1'b0; f1.araddr = 32'h0; f1.arvalid = 1'b0; f1.rready = 1'b0;
        sl.awready = 1'b0; sl.wready = 1'b0; sl.bresp = 2'b00; sl.bvalid = 1'b0;
        sl.arready = 1'b0; sl.rdata = 32'h0; sl.rresp = 2'b00; sl.rvalid = 1'b0;
        fs.awready = 1'b0; fs.wready = 1'b0; fs.bresp = 2'b00; fs.bvalid = 1'b0;
        fs.arready = 1'b0; fs.rdata = 32'h0; fs.rresp = 2'b00; fs.rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset_n = 1'b0;
        m0.arvalid = 1'b1; m1.awvalid = 1'b1; sl.arready = 1'b1; sl.awready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        total++; if (sl.arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", sl.arvalid); end
        total++; if (sl.awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid got=%b exp=0", sl.awvalid); end
        total++; if (m0.arready !== 1'b0) begin bad++; $display("FAIL rst_m0_arready got=%b exp=0", m0.arready); end
        total++; if (m1.awready !== 1'b0) begin bad++; $display("FAIL rst_m1_awready got=%b exp=0", m1.awready); end
        total++; if (sl.araddr !== 32'h0) begin bad++; $display("FAIL rst_araddr got=%h exp=0", sl.araddr); end
        clear_inputs();
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single_read();
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_0010; m0.rready = 1'b1; sl.arready = 1'b1;
        #1;
        total++; if (sl.arvalid !== 1'b0) begin bad++; $display("FAIL rd_idle_arvalid got=%b exp=0", sl.arvalid); end
        @(negedge aclk);
        total++; if (sl.arvalid !== 1'b1) begin bad++; $display("FAIL rd_arvalid got=%b exp=1", sl.arvalid); end
        total++; if (sl.araddr !== 32'h0000_0010) begin bad++; $display("FAIL rd_araddr got=%h exp=00000010", sl.araddr); end
        total++; if (m0.arready !== 1'b1) begin bad++; $display("FAIL rd_m0_arready got=%b exp=1", m0.arready); end
        total++; if (m1.arready !== 1'b0) begin bad++; $display("FAIL rd_m1_arready got=%b exp=0", m1.arready); end
        @(negedge aclk);
        m0.arvalid = 1'b0;
        sl.rvalid = 1'b1; sl.rdata = 32'hDEAD_BEEF; sl.rresp = 2'b00;
        #1;
        total++; if (sl.arvalid !== 1'b0) begin bad++; $display("FAIL rd_data_arvalid got=%b exp=0", sl.arvalid); end
        total++; if (m0.rvalid !== 1'b1) begin bad++; $display("FAIL rd_m0_rvalid got=%b exp=1", m0.rvalid); end
        total++; if (m0.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_m0_rdata got=%h exp=deadbeef", m0.rdata); end
        total++; if (m0.rresp !== 2'b00) begin bad++; $display("FAIL rd_m0_rresp got=%b exp=00", m0.rresp); end
        total++; if (sl.rready !== 1'b1) begin bad++; $display("FAIL rd_rready got=%b exp=1", sl.rready); end
        total++; if (m1.rvalid !== 1'b0) begin bad++; $display("FAIL rd_m1_rvalid got=%b exp=0", m1.rvalid); end
        @(negedge aclk);
        sl.rvalid = 1'b0;
        #1;
        total++; if (sl.rready !== 1'b0) begin bad++; $display("FAIL rd_idle_rready got=%b exp=0", sl.rready); end
        total++; if (m0.rdata !== 32'h0) begin bad++; $display("FAIL rd_idle_rdata got=%h exp=0", m0.rdata); end
        clear_inputs();
    endtask

    task automatic test_read_arb();
        logic [31:0] exp_rr;
        do_reset();
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_0100; m0.rready = 1'b1;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_0200; m1.rready = 1'b1;
        f0.arvalid = 1'b1; f0.araddr = 32'h0000_0100; f0.rready = 1'b1;
        f1.arvalid = 1'b1; f1.araddr = 32'h0000_0200; f1.rready = 1'b1;
        sl.arready = 1'b1; fs.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            @(negedge aclk);
            total++; if (sl.araddr !== exp_rr) begin bad++; $display("FAIL rr_grant%0d got=%h exp=%h", i, sl.araddr, exp_rr); end
            total++; if ({m1.arready, m0.arready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_arready%0d got=%b%b", i, m1.arready, m0.arready); end
            total++; if (fs.araddr !== 32'h0000_0100) begin bad++; $display("FAIL fp_grant%0d got=%h exp=00000100", i, fs.araddr); end
            total++; if (f1.arready !== 1'b0) begin bad++; $display("FAIL fp_m1_arready%0d got=%b exp=0", i, f1.arready); end
            @(negedge aclk);
            sl.rvalid = 1'b1; sl.rdata = 32'h0 + i; fs.rvalid = 1'b1; fs.rdata = 32'h0 + i;
            #1;
            total++; if ({m1.rvalid, m0.rvalid} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_rvalid%0d got=%b%b", i, m1.rvalid, m0.rvalid); end
            total++; if ({m1.arready, m0.arready} !== 2'b00) begin bad++; $display("FAIL rr_data_arready%0d got=%b%b exp=00", i, m1.arready, m0.arready); end
            @(negedge aclk);
            sl.rvalid = 1'b0; fs.rvalid = 1'b0;
        end
        m0.arvalid = 1'b0; m1.arvalid = 1'b0; f0.arvalid = 1'b0;
        @(negedge aclk);
        total++; if (fs.araddr !== 32'h0000_0200) begin bad++; $display("FAIL fp_m1_after got=%h exp=00000200", fs.araddr); end
        total++; if ({f1.arready, f0.arready} !== 2'b10) begin bad++; $display("FAIL fp_m1_arready got=%b%b exp=10", f1.arready, f0.arready); end
        total++; if (sl.arvalid !== 1'b0) begin bad++; $display("FAIL rr_stays_idle got=%b exp=0", sl.arvalid); end
        f1.arvalid = 1'b0;
        @(negedge aclk);
        fs.rvalid = 1'b1;
        @(negedge aclk);
        clear_inputs();
        @(negedge aclk);
    endtask

    task automatic test_write_w_first();
        m1.awvalid = 1'b1; m1.awaddr = 32'h0000_0020; m1.wvalid = 1'b1;
        m1.wdata = 32'h1234_5678; m1.wstrb = 4'hF; m1.bready = 1'b1;
        @(negedge aclk);
        total++; if ({sl.awvalid, sl.wvalid} !== 2'b11) begin bad++; $display("FAIL wr_valids got=%b%b exp=11", sl.awvalid, sl.wvalid); end
        total++; if (sl.awaddr !== 32'h0000_0020) begin bad++; $display("FAIL wr_awaddr got=%h exp=00000020", sl.awaddr); end
        total++; if (sl.wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", sl.wdata); end
        total++; if (sl.wstrb !== 4'hF) begin bad++; $display("FAIL wr_wstrb got=%h exp=f", sl.wstrb); end
        sl.wready = 1'b1;
        #1;
        total++; if ({m1.wready, m0.wready} !== 2'b10) begin bad++; $display("FAIL wr_wready got=%b%b exp=10", m1.wready, m0.wready); end
        @(negedge aclk);
        total++; if (sl.wvalid !== 1'b0) begin bad++; $display("FAIL wr_wvalid_after got=%b exp=0", sl.wvalid); end
        total++; if (m1.wready !== 1'b0) begin bad++; $display("FAIL wr_wready_after got=%b exp=0", m1.wready); end
        total++; if (sl.awvalid !== 1'b1) begin bad++; $display("FAIL wr_awvalid_hold got=%b exp=1", sl.awvalid); end
        @(negedge aclk);
        total++; if (sl.bready !== 1'b0) begin bad++; $display("FAIL wr_no_resp_yet got=%b exp=0", sl.bready); end
        sl.awready = 1'b1;
        @(negedge aclk);
        m1.awvalid = 1'b0; m1.wvalid = 1'b0; sl.awready = 1'b0; sl.wready = 1'b0;
        sl.bvalid = 1'b1; sl.bresp = 2'b10;
        #1;
        total++; if (sl.awvalid !== 1'b0) begin bad++; $display("FAIL wr_resp_awvalid got=%b exp=0", sl.awvalid); end
        total++; if (sl.bready !== 1'b1) begin bad++; $display("FAIL wr_bready got=%b exp=1", sl.bready); end
        total++; if (m1.bvalid !== 1'b1) begin bad++; $display("FAIL wr_m1_bvalid got=%b exp=1", m1.bvalid); end
        total++; if (m1.bresp !== 2'b10) begin bad++; $display("FAIL wr_m1_bresp got=%b exp=10", m1.bresp); end
        total++; if (m0.bvalid !== 1'b0) begin bad++; $display("FAIL wr_m0_bvalid got=%b exp=0", m0.bvalid); end
        @(negedge aclk);
        sl.bvalid = 1'b0;
        #1;
        total++; if (sl.bready !== 1'b0) begin bad++; $display("FAIL wr_idle_bready got=%b exp=0", sl.bready); end
        clear_inputs();
    endtask

    task automatic test_concurrent();
        m0.awvalid = 1'b1; m0.awaddr = 32'h0000_0030; m0.wvalid = 1'b1;
        m0.wdata = 32'hCAFE_0001; m0.wstrb = 4'h3; m0.bready = 1'b1;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_0040; m1.rready = 1'b1;
        sl.awready = 1'b1; sl.wready = 1'b1; sl.arready = 1'b1;
        @(negedge aclk);
        total++; if ({sl.arvalid, sl.awvalid, sl.wvalid} !== 3'b111) begin
            bad++; $display("FAIL cc_valids got=%b%b%b exp=111", sl.arvalid, sl.awvalid, sl.wvalid); end
        total++; if (sl.araddr !== 32'h0000_0040) begin bad++; $display("FAIL cc_araddr got=%h exp=00000040", sl.araddr); end
        total++; if (sl.awaddr !== 32'h0000_0030) begin bad++; $display("FAIL cc_awaddr got=%h exp=00000030", sl.awaddr); end
        total++; if ({m1.arready, m0.awready, m0.wready} !== 3'b111) begin
            bad++; $display("FAIL cc_readies got=%b%b%b exp=111", m1.arready, m0.awready, m0.wready); end
        total++; if ({m0.arready, m1.awready} !== 2'b00) begin bad++; $display("FAIL cc_other_readies got=%b%b exp=00", m0.arready, m1.awready); end
        @(negedge aclk);
        clear_inputs();
        m0.bready = 1'b1; m1.rready = 1'b1;
        sl.rvalid = 1'b1; sl.rdata = 32'h55AA_55AA; sl.bvalid = 1'b1; sl.bresp = 2'b00;
        #1;
        total++; if (m1.rvalid !== 1'b1) begin bad++; $display("FAIL cc_m1_rvalid got=%b exp=1", m1.rvalid); end
        total++; if (m1.rdata !== 32'h55AA_55AA) begin bad++; $display("FAIL cc_m1_rdata got=%h exp=55aa55aa", m1.rdata); end
        total++; if ({m0.rvalid, m1.bvalid} !== 2'b00) begin bad++; $display("FAIL cc_misroute got=%b%b exp=00", m0.rvalid, m1.bvalid); end
        total++; if (m0.bvalid !== 1'b1) begin bad++; $display("FAIL cc_m0_bvalid got=%b exp=1", m0.bvalid); end
        @(negedge aclk);
        clear_inputs();
        #1;
        total++; if ({sl.rready, sl.bready} !== 2'b00) begin bad++; $display("FAIL cc_idle got=%b%b exp=00", sl.rready, sl.bready); end
    endtask

    task automatic test_reset_rd_data();
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_0050; m0.rready = 1'b1; sl.arready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        m0.arvalid = 1'b0;
        sl.rvalid = 1'b1; sl.rdata = 32'hFEED_0000;
        #1;
        total++; if ({sl.rready, m0.rvalid} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b%b exp=11", sl.rready, m0.rvalid); end
        #1;
        areset_n = 1'b0;
        #1;
        total++; if (sl.rready !== 1'b0) begin bad++; $display("FAIL rst_async_rready got=%b exp=0", sl.rready); end
        total++; if (m0.rvalid !== 1'b0) begin bad++; $display("FAIL rst_async_rvalid got=%b exp=0", m0.rvalid); end
        clear_inputs();
        @(negedge aclk);
        areset_n = 1'b1;
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_0060;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_0070;
        @(negedge aclk);
        total++; if (sl.araddr !== 32'h0000_0060) begin bad++; $display("FAIL rst_tie_m0 got=%h exp=00000060", sl.araddr); end
        total++; if (m1.arready !== 1'b0) begin bad++; $display("FAIL rst_tie_m1_arready got=%b exp=0", m1.arready); end
        clear_inputs();
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        clear_inputs();
        areset_n = 1'b0;
        @(negedge aclk);
        test_reset();
        test_single_read();
        test_read_arb();
        test_write_w_first();
        test_concurrent();
        test_reset_rd_data();
        @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
AXI_LITE_ARBITER_2TO1 -- requirements
Module: axi_lite_arbiter_2to1

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with m0 highest.
REQ-002 SHALL have port aclk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port areset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port m0, axi_lite_if.slave modport: requester 0 (upstream master connects here).
REQ-005 SHALL have port m1, axi_lite_if.slave modport: requester 1.
REQ-006 SHALL have port s, axi_lite_if.master modport: the single shared downstream AXI4-Lite slave.
REQ-007 SHALL use addr_t, data_t, strb_t and resp_t from axi_lite_pkg for all channel widths; no width conversion.

Function
REQ-008 SHALL run read path (AR/R) and write path (AW/W/B) as independent FSMs with separate grants; a read and a write may be in flight concurrently.
REQ-009 SHALL allow at most one outstanding transaction per path.
REQ-010 SHALL implement read FSM states RD_IDLE, RD_ADDR, RD_DATA.
  - RD_IDLE -> RD_ADDR when any mX.arvalid = 1; grant is registered on this edge.
  - RD_ADDR -> RD_DATA on s.arvalid && s.arready.
  - RD_DATA -> RD_IDLE on s.rvalid && s.rready.
REQ-011 SHALL, in RD_ADDR, drive s.arvalid = 1 and s.araddr = granted araddr; granted arready = s.arready (combinational).
REQ-012 SHALL, in RD_DATA, drive granted rvalid/rdata/rresp = s.rvalid/rdata/rresp and s.rready = granted rready.
REQ-013 SHALL implement write FSM states WR_IDLE, WR_XFER, WR_RESP.
  - WR_IDLE -> WR_XFER when any mX.awvalid = 1; arbitration considers awvalid only.
  - WR_XFER -> WR_RESP once both aw_done and w_done are set.
  - WR_RESP -> WR_IDLE on s.bvalid && s.bready.
REQ-014 SHALL, in WR_XFER, forward AW and W of the grantee independently.
  - s.awvalid = granted awvalid && !aw_done; s.wvalid = granted wvalid && !w_done.
  - Set each done flag on its handshake.
  - If both handshakes occur in the same cycle, go straight to WR_RESP.
  - Clear both flags on entry to WR_IDLE.
REQ-015 SHALL, in WR_RESP, forward bvalid/bresp to the grantee and drive s.bready = granted bready.
REQ-016 SHALL resolve grants as follows.
  - RR_EN = 1: on a simultaneous request, grant the master not granted last on that path.
  - RR_EN = 0: on a simultaneous request, grant m0.
  - Single requester: that requester wins.
  - Last-grant register per path updates when the grant is taken.
REQ-017 SHALL drive all non-granted (or idle-path) outputs to 0.
  - Applies to arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp.
  - Applies to s.arvalid, s.awvalid, s.wvalid, s.rready, s.bready.
  - Applies to s.araddr, s.awaddr, s.wdata, s.wstrb.
REQ-018 SHALL never switch a grant mid-transaction.
  - After grant, the block does not re-sample arvalid/awvalid.
  - AXI valid-hold rules oblige requesters to keep valid asserted.
REQ-019 SHALL give minimum latency of one cycle from mX.arvalid/awvalid rising in IDLE to s.arvalid/awvalid = 1.
REQ-020 SHALL have no combinational path from s.* to s.* outputs; mX→s and s→mX paths are combinational only through the grant mux.

Reset
REQ-021 SHALL, while areset_n = 0:
  - Hold both FSMs in IDLE and clear aw_done/w_done.
  - Set both last-grant registers to m1, so m0 wins the first tie.
  - Drive all outputs per REQ-017.
REQ-022 SHALL, on reset assertion mid-transaction, abandon the transaction immediately (asynchronously) with all valids/readies at 0; no response is generated for the abandoned transfer.

Verification
REQ-023 SHALL cover single read.
  - Stimulus: m0 reads 0x0000_0010; slave arready = 1, rdata = 0xDEAD_BEEF, rresp = OKAY.
  - Required: s.arvalid high 1 cycle after m0.arvalid; m0 receives 0xDEAD_BEEF/OKAY; FSM returns to RD_IDLE.
REQ-024 SHALL cover read round-robin.
  - Stimulus: m0 and m1 assert arvalid together, both held for 4 transactions, RR_EN = 1.
  - Required: grant order m0, m1, m0, m1; non-granted arready = 0 throughout.
REQ-025 SHALL cover fixed priority.
  - Stimulus: same as REQ-024 with RR_EN = 0.
  - Required: m0 granted 4 times in a row; m1 granted only after m0 drops arvalid.
REQ-026 SHALL cover write, W before AW.
  - Stimulus: m1 writes 0x20, wdata 0x1234_5678, wstrb 0xF; slave takes W at cycle 2 and AW at cycle 4, bresp = SLVERR.
  - Required: w_done set at cycle 2, s.wvalid low afterwards, WR_RESP after AW; m1 sees bresp = SLVERR.
REQ-027 SHALL cover concurrent read and write.
  - Stimulus: m0 write and m1 read started in the same cycle.
  - Required: both proceed without stalling each other, and each response is routed to the correct master.
REQ-028 SHALL cover reset in RD_DATA.
  - Stimulus: assert areset_n = 0 mid-cycle while in RD_DATA.
  - Required: s.rready and m0.rvalid go 0 without waiting for an edge; after release, a tie grants m0 first.
